// File: rtl/pla_seq_eval_if.sv
// pla_seq_eval_if: config, request and result signals of the sequential PLA evaluator
interface pla_seq_eval_if #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 11,
  parameter int AW    = 6
);
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [2*N_IN-1:0]   cfg_in_cube;
  logic [N_OUT-1:0]    cfg_out_mask;
  logic                cfg_pol_we;
  logic [N_OUT-1:0]    cfg_pol;
  logic                cfg_drop;
  logic                in_valid;
  logic                in_ready;
  logic [N_IN-1:0]     in_x;
  logic                out_valid;
  logic                out_ready;
  logic [N_OUT-1:0]    out_z;
  logic                busy;
  modport master (
    output cfg_we, cfg_addr, cfg_in_cube, cfg_out_mask, cfg_pol_we, cfg_pol,
    output in_valid, in_x, out_ready,
    input  cfg_drop, in_ready, out_valid, out_z, busy
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_in_cube, cfg_out_mask, cfg_pol_we, cfg_pol,
    input  in_valid, in_x, out_ready,
    output cfg_drop, in_ready, out_valid, out_z, busy
  );
endinterface

// File: rtl/pla_seq_eval.sv
// pla_seq_eval: time-multiplexed programmable sum-of-products evaluator
module pla_seq_eval #(
  parameter int N_IN    = 15,
  parameter int N_OUT   = 11,
  parameter int N_TERMS = 64,
  parameter int LANES   = 1,
  parameter int AW      = $clog2(N_TERMS)
) (
  input logic clk,
  input logic rst,
  pla_seq_eval_if.slave bus
);
  localparam int NG = N_TERMS / LANES;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t              state, state_n;
  logic [2*N_IN-1:0]   cube [N_TERMS];
  logic [N_OUT-1:0]    mask [N_TERMS];
  logic [N_OUT-1:0]    pol;
  logic [N_OUT-1:0]    acc;
  logic [N_OUT-1:0]    grp_or;
  logic [N_OUT-1:0]    z_q;
  logic [N_IN-1:0]     x_lat;
  logic [GW-1:0]       grp;
  logic                drop_q;
  logic                accept;
  logic                last;
  // A variable matches when the cube bit selected by its value is set; 00 never matches.
  function automatic logic fires(input logic [2*N_IN-1:0] c, input logic [N_IN-1:0] x);
    fires = 1'b1;
    for (int i = 0; i < N_IN; i++) fires &= x[i] ? c[2*i+1] : c[2*i];
  endfunction
  assign accept        = state == IDLE && bus.in_valid;
  assign last          = grp == GW'(NG - 1);
  assign bus.in_ready  = state == IDLE && !rst;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.out_z     = z_q;
  assign bus.cfg_drop  = drop_q;
  // OR of the masks of the terms in the current group that fire on the latched vector
  always_comb begin
    grp_or = '0;
    for (int l = 0; l < LANES; l++)
      grp_or |= fires(cube[AW'(int'(grp) * LANES + l)], x_lat) ? mask[AW'(int'(grp) * LANES + l)] : '0;
  end
  // Next-state: accept in IDLE, sweep all groups in EVAL, hold result until consumed
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = EVAL;
    if (state == EVAL && last) state_n = DONE;
    if (state == DONE && bus.out_ready) state_n = IDLE;
  end
  // State, term table, phase register and evaluation datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pol    <= '0;
      acc    <= '0;
      z_q    <= '0;
      x_lat  <= '0;
      grp    <= '0;
      drop_q <= 1'b0;
      for (int t = 0; t < N_TERMS; t++) begin
        cube[t] <= '0;
        mask[t] <= '0;
      end
    end else begin
      state  <= state_n;
      drop_q <= (bus.cfg_we || bus.cfg_pol_we) && state != IDLE;
      if (state == IDLE) begin
        if (bus.cfg_we) begin
          cube[bus.cfg_addr] <= bus.cfg_in_cube;
          mask[bus.cfg_addr] <= bus.cfg_out_mask;
        end
        if (bus.cfg_pol_we) pol <= bus.cfg_pol;
      end
      if (accept) begin
        x_lat <= bus.in_x;
        acc   <= '0;
        grp   <= '0;
      end
      if (state == EVAL) begin
        acc <= acc | grp_or;
        grp <= grp + GW'(1);
        if (last) z_q <= (acc | grp_or) ^ pol;
      end
    end
  end
endmodule
